// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the seven-segment scanner.
// Segment vectors are abcdefg with a in bit 0 and g in bit 6.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b0111111;
    localparam seg7_t SEG_1     = 7'b0000110;
    localparam seg7_t SEG_2     = 7'b1011011;
    localparam seg7_t SEG_3     = 7'b1001111;
    localparam seg7_t SEG_4     = 7'b1100110;
    localparam seg7_t SEG_5     = 7'b1101101;
    localparam seg7_t SEG_6     = 7'b1111101;
    localparam seg7_t SEG_7     = 7'b0000111;
    localparam seg7_t SEG_8     = 7'b1111111;
    localparam seg7_t SEG_9     = 7'b1100111;
    localparam seg7_t SEG_A     = 7'b1110111;
    localparam seg7_t SEG_B     = 7'b1111100;
    localparam seg7_t SEG_C     = 7'b0111001;
    localparam seg7_t SEG_D     = 7'b1011110;
    localparam seg7_t SEG_E     = 7'b1111001;
    localparam seg7_t SEG_F     = 7'b1110001;
    localparam seg7_t SEG_BLANK = 7'b0000000;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Value-load bus into the scanner: packed nibbles, decimal points,
// blanking enable and the one-cycle load strobe.
interface seven_seg_scanner_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] i_value;
    logic [DIGITS-1:0]   i_dp;
    logic                i_load;
    logic                i_blank_lz;

    modport master (
        output i_value,
        output i_dp,
        output i_load,
        output i_blank_lz
    );

    modport slave (
        input  i_value,
        input  i_dp,
        input  i_load,
        input  i_blank_lz
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational hex-nibble to seven-segment decoder with a blank override.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output seg7_t      o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_nibble)
                4'h0: o_seg = SEG_0;
                4'h1: o_seg = SEG_1;
                4'h2: o_seg = SEG_2;
                4'h3: o_seg = SEG_3;
                4'h4: o_seg = SEG_4;
                4'h5: o_seg = SEG_5;
                4'h6: o_seg = SEG_6;
                4'h7: o_seg = SEG_7;
                4'h8: o_seg = SEG_8;
                4'h9: o_seg = SEG_9;
                4'hA: o_seg = SEG_A;
                4'hB: o_seg = SEG_B;
                4'hC: o_seg = SEG_C;
                4'hD: o_seg = SEG_D;
                4'hE: o_seg = SEG_E;
                4'hF: o_seg = SEG_F;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver with frame-synchronous value commit,
// guard gap between digit slots and optional leading-zero blanking.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned GUARD      = 2,
    parameter bit          ACTIVE_LOW = 1'b0
)(
    input  logic                i_clk,
    input  logic                i_rst,
    seven_seg_scanner_if.slave  i_bus,
    output logic [6:0]          o_segments,
    output logic                o_dp,
    output logic [DIGITS-1:0]   o_digit_en,
    output logic                o_frame
);

    localparam int unsigned IW = idx_width(DIGITS);
    localparam int unsigned PW = idx_width(SCAN_DIV);

    localparam seg7_t             SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] EN_POL  = {DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;

    logic [4*DIGITS-1:0] r_pend_value;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_blank_lz;
    logic                r_pend_flag;

    logic [4*DIGITS-1:0] r_disp_value;
    logic [DIGITS-1:0]   r_disp_dp;
    logic                r_disp_blank_lz;

    logic [6:0]          r_segments;
    logic                r_dp;
    logic [DIGITS-1:0]   r_digit_en;
    logic                r_frame;

    logic                w_tick;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_lz_blank;
    logic                w_upper_zero;
    logic [3:0]          w_nibble;
    logic                w_blank;
    logic                w_dp_sel;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_en;
    seg7_t               w_glyph;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == IW'(DIGITS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // A load coinciding with the wrap bypasses the pending stage; the wrap's
    // flag clear is ordered last so the flag always ends cleared.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_value    <= '0;
            r_pend_dp       <= '0;
            r_pend_blank_lz <= 1'b0;
            r_pend_flag     <= 1'b0;
            r_disp_value    <= '0;
            r_disp_dp       <= '0;
            r_disp_blank_lz <= 1'b0;
        end else begin
            if (i_bus.i_load) begin
                r_pend_value    <= i_bus.i_value;
                r_pend_dp       <= i_bus.i_dp;
                r_pend_blank_lz <= i_bus.i_blank_lz;
                r_pend_flag     <= 1'b1;
            end
            if (w_wrap) begin
                r_pend_flag <= 1'b0;
                if (i_bus.i_load) begin
                    r_disp_value    <= i_bus.i_value;
                    r_disp_dp       <= i_bus.i_dp;
                    r_disp_blank_lz <= i_bus.i_blank_lz;
                end else if (r_pend_flag) begin
                    r_disp_value    <= r_pend_value;
                    r_disp_dp       <= r_pend_dp;
                    r_disp_blank_lz <= r_pend_blank_lz;
                end
            end
        end
    end

    // Digit k blanks when it and every more-significant nibble are zero.
    always_comb begin
        w_lz_blank   = '0;
        w_upper_zero = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            w_upper_zero  = w_upper_zero & (r_disp_value[4*k +: 4] == 4'h0);
            w_lz_blank[k] = r_disp_blank_lz & w_upper_zero;
        end
    end

    always_comb begin
        w_nibble = '0;
        w_blank  = 1'b0;
        w_dp_sel = 1'b0;
        w_onehot = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nibble    = r_disp_value[4*k +: 4];
                w_blank     = w_lz_blank[k];
                w_dp_sel    = r_disp_dp[k];
                w_onehot[k] = 1'b1;
            end
        end
        w_en = (r_presc < PW'(GUARD)) ? '0 : w_onehot;
    end

    seg7_glyph u_glyph (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_glyph)
    );

    // Polarity is folded into the register inputs so the pins are flop outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_segments <= SEG_POL;
            r_dp       <= ACTIVE_LOW;
            r_digit_en <= EN_POL;
            r_frame    <= ACTIVE_LOW;
        end else begin
            r_segments <= w_glyph ^ SEG_POL;
            r_dp       <= w_dp_sel ^ ACTIVE_LOW;
            r_digit_en <= w_en ^ EN_POL;
            r_frame    <= w_wrap ^ ACTIVE_LOW;
        end
    end

    assign o_segments = r_segments;
    assign o_dp       = r_dp;
    assign o_digit_en = r_digit_en;
    assign o_frame    = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench: an active-high and an active-low scanner share one stimulus
// stream and are checked cycle by cycle against hand-written glyph vectors.
module tb_seven_seg_scanner;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned GUARD    = 2;

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] BL = 7'b0000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_seg_scanner_if #(.DIGITS(DIGITS)) bus ();

    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l;
    logic [3:0] en_h, en_l;
    logic       frm_h, frm_l;

    seven_seg_scanner #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_bus(bus),
        .o_segments(seg_h), .o_dp(dp_h), .o_digit_en(en_h), .o_frame(frm_h)
    );

    seven_seg_scanner #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .i_clk(clk), .i_rst(rst), .i_bus(bus),
        .o_segments(seg_l), .o_dp(dp_l), .o_digit_en(en_l), .o_frame(frm_l)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_outputs(input logic [6:0] s, input logic d, input logic [3:0] e,
                                 input logic f, input string tag);
        logic [6:0] si;
        logic       di;
        logic [3:0] ei;
        logic       fi;
        si = ~s;
        di = ~d;
        ei = ~e;
        fi = ~f;
        chk({tag, "_seg"},    {25'b0, seg_h}, {25'b0, s});
        chk({tag, "_dp"},     {31'b0, dp_h},  {31'b0, d});
        chk({tag, "_en"},     {28'b0, en_h},  {28'b0, e});
        chk({tag, "_frm"},    {31'b0, frm_h}, {31'b0, f});
        chk({tag, "_seg_al"}, {25'b0, seg_l}, {25'b0, si});
        chk({tag, "_dp_al"},  {31'b0, dp_l},  {31'b0, di});
        chk({tag, "_en_al"},  {28'b0, en_l},  {28'b0, ei});
        chk({tag, "_frm_al"}, {31'b0, frm_l}, {31'b0, fi});
    endtask

    // Starts on the negedge just after a frame pulse; ends on the next one.
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
        logic [3:0] e;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                e = (c < 2) ? 4'b0000 : (4'b0001 << s);
                check_outputs(segs[7*s +: 7], dps[s], e, (s == 3 && c == 7),
                              $sformatf("%s_d%0d_c%0d", tag, s, c));
            end
        end
    endtask

    task automatic wait_frame(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = frm_h;
        end
        chk({tag, "_frame_seen"}, {31'b0, found}, 32'd1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic blz);
        bus.i_value    = v;
        bus.i_dp       = d;
        bus.i_blank_lz = blz;
        bus.i_load     = 1'b1;
        step();
        bus.i_load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] e;
        int p;
        rst            = 1'b1;
        bus.i_value    = '0;
        bus.i_dp       = '0;
        bus.i_blank_lz = 1'b0;
        bus.i_load     = 1'b0;
        step();
        step();
        check_outputs(BL, 1'b0, 4'b0000, 1'b0, "reset");
        rst = 1'b0;

        // First frame after reset: all-zero display, load 0x12A5 mid-frame.
        for (int ed = 1; ed <= 32; ed++) begin
            step();
            p = ed - 1;
            e = ((p % 8) < 2) ? 4'b0000 : (4'b0001 << (p / 8));
            check_outputs(G0, 1'b0, e, (p == 31), $sformatf("boot_e%0d", ed));
            if (ed == 5) begin
                bus.i_value    = 16'h12A5;
                bus.i_dp       = 4'b0000;
                bus.i_blank_lz = 1'b0;
                bus.i_load     = 1'b1;
            end
            if (ed == 6) bus.i_load = 1'b0;
        end
        check_frame({G1, G2, GA, G5}, 4'b0000, "v12A5");

        load(16'h0070, 4'b0100, 1'b1);
        wait_frame("lz70");
        check_frame({BL, BL, G7, G0}, 4'b0100, "lz70");

        load(16'h0000, 4'b0000, 1'b1);
        wait_frame("lz00");
        check_frame({BL, BL, BL, G0}, 4'b0000, "lz00");

        load(16'h1111, 4'b0000, 1'b0);
        repeat (3) step();
        load(16'h2222, 4'b0000, 1'b0);
        wait_frame("last_wins");
        check_frame({G2, G2, G2, G2}, 4'b0000, "last_wins");

        // Strobe coincides with the wrap edge: committed by bypass.
        repeat (31) step();
        bus.i_value    = 16'h3333;
        bus.i_dp       = 4'b0000;
        bus.i_blank_lz = 1'b0;
        bus.i_load     = 1'b1;
        step();
        bus.i_load = 1'b0;
        chk("bypass_wrap_frame", {31'b0, frm_h}, 32'd1);
        check_frame({G3, G3, G3, G3}, 4'b0000, "bypass");

        // Reset during digit 2 with a pending value.
        repeat (19) step();
        load(16'h4444, 4'b1111, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        #1;
        check_outputs(BL, 1'b0, 4'b0000, 1'b0, "async_rst");
        step();
        rst = 1'b0;
        repeat (3) step();
        check_outputs(G0, 1'b0, 4'b0001, 1'b0, "restart");
        wait_frame("post_rst");
        check_frame({G0, G0, G0, G0}, 4'b0000, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
